ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of the MIPS decode/execute datapath and replaces the combinational instruction-memory read.
- Owns the fetch PC and issues word-addressed requests to an instruction memory with variable latency over a req/ack handshake.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to the core over a valid/ready interface.
- Handles control-flow redirects (jumps/branches) by flushing the FIFO and discarding any in-flight response.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 32, PC/address width; the PC is a word address and advances by 1
DATA_W, 32, instruction width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
mem_req  out  1  fetch request to instruction memory (registered)
mem_addr  out  ADDR_W  word address of request (registered)
mem_ack  in  1  memory accepts request; mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  instruction word returned with mem_ack
redirect  in  1  control-flow change from core (jump/branch taken)
redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
inst_valid  out  1  FIFO head holds a valid instruction
inst_data  out  DATA_W  instruction at FIFO head
inst_pc  out  ADDR_W  PC of instruction at FIFO head
inst_ready  in  1  core consumes head when inst_valid&&inst_ready

Behaviour:
- Reset (clock edge with reset=1): fetch_pc=0, FIFO empty, state IDLE, mem_req=0, mem_addr=0, inst_valid=0. inst_data and inst_pc read 0 while empty. Reset overrides redirect and all handshakes, and applies from any state; an in-flight memory response is dropped by the memory side.
- States:
  - IDLE: no request outstanding.
  - REQ: mem_req=1, waiting for ack.
  - DROP: mem_req=1 for a stale address; its data must be discarded.
- Handshake rules:
  - Once mem_req is high, mem_req and mem_addr stay constant until the cycle mem_ack=1.
  - mem_ack while mem_req=0 is ignored.
  - At most one request is outstanding.
- Issue:
  - IDLE -> REQ when count_next < DEPTH, with mem_addr<=fetch_pc.
  - count_next is the occupancy after this cycle's push/pop/flush.
- Ack in REQ:
  - Push {fetch_pc, mem_rdata} and set fetch_pc<=fetch_pc+1 (wraps 0xFFFFFFFF->0).
  - If count_next < DEPTH, stay in REQ with mem_addr<=fetch_pc+1, giving back-to-back fetches: one instruction per cycle with zero-wait memory.
  - Otherwise go to IDLE with mem_req<=0.
- Latency: mem_ack at edge N -> inst_valid=1 with that data after edge N (visible in cycle N+1). A push is never performed when the FIFO is full; the issue guard guarantees this.
- Pop: on inst_valid&&inst_ready, the head advances. Push and pop in the same cycle leave count unchanged. Read/write pointers wrap modulo DEPTH. Outputs are driven combinationally from head storage.
- Redirect (highest priority after reset):
  - Flush the FIFO (count=0, inst_valid=0 next cycle). A pop in the same cycle is ignored.
  - fetch_pc<=redirect_pc.
  - From IDLE: go to REQ at redirect_pc next cycle.
  - From REQ with mem_ack=1 the same cycle: discard rdata and go to REQ at redirect_pc.
  - From REQ with mem_ack=0: go to DROP. The request is held unchanged until ack.
  - From DROP: only fetch_pc is updated; the latest redirect wins.
- DROP + mem_ack: discard rdata, then REQ with mem_addr<=fetch_pc (the redirect target). No stale instruction ever reaches inst_*.
- Simultaneous push+redirect: the redirect wins and nothing is pushed.

Test Plan:
- Zero-wait memory (mem_ack=mem_req), inst_ready=1 after reset -> inst_pc sequence 0,1,2,3… at 1/cycle; first inst_valid 2 cycles after reset release; inst_data equals mem image[pc].
- inst_ready=0, memory always acking -> exactly DEPTH=4 entries fetched (PCs 0–3); mem_req low after the 4th ack. Set inst_ready=1 -> PCs 0..3 popped in order, then fetching resumes at 4 with no duplicates or gaps.
- Memory with 3-cycle ack latency -> mem_addr stable across the wait; inst_pc strictly sequential; throughput 1 per 4 cycles.
- Redirect to 0x100 while a request to 0x7 is waiting (ack 2 cycles later) -> FIFO empties next cycle; the ack for 0x7 is discarded; next mem_addr=0x100; first inst_pc after redirect =0x100.
- Redirect to 0x40 in the same cycle as mem_ack and inst_ready -> no push and no pop; next request at 0x40. A second redirect to 0x80 during DROP -> resumes at 0x80.
- Assert reset mid-REQ with 2 entries queued -> next cycle inst_valid=0, mem_req=0; after release, fetch restarts at PC 0.

Source files
------------

// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, talks to a variable-latency
// instruction memory over req/ack, and queues PC-tagged instructions for decode.

module ifetch_buffer_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc,
  output logic [CNT_W-1:0]  count_next
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_en, pop_en;

  // A flush discards both the incoming push and any same-cycle pop.
  always_comb begin
    push_en  = push && !flush;
    pop_en   = pop && !flush && (count_q != '0);
    data_d   = data_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        data_d[wr_ptr_q] = push_data;
        pc_d[wr_ptr_q]   = push_pc;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
    count_next = count_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  // Head is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    valid     = (count_q != '0);
    head_data = valid ? data_q[rd_ptr_q] : '0;
    head_pc   = valid ? pc_q[rd_ptr_q] : '0;
  end

endmodule

module ifetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              room;

  assign push = (state_q == REQ) && mem_ack;

  ifetch_buffer_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (mem_rdata),
    .push_pc   (fetch_pc_q),
    .pop       (inst_valid && inst_ready),
    .valid     (inst_valid),
    .head_data (inst_data),
    .head_pc   (inst_pc),
    .count_next(count_next)
  );

  assign room = (count_next < CNT_W'(DEPTH));

  // Request fields only change on ack, so the memory sees a stable request.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc;
        end else if (room) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (mem_ack) begin
            mem_addr_d = redirect_pc;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          if (room) begin
            mem_addr_d = fetch_pc_q + ADDR_W'(1);
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_ack) begin
          state_d    = REQ;
          mem_addr_d = redirect ? redirect_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed self-checking bench for ifetch_buffer with a small instruction-memory
// responder that is either auto-acking with fixed latency or hand-driven.

module tb_ifetch_buffer;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int   checks;
  int   failures;
  logic mem_auto;
  int   ack_latency;
  int   wait_cnt;

  ifetch_buffer #(
    .DEPTH (4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge; outputs seen right after
  // reflect the state from the previous rising edge.
  task automatic applyStimulus(input logic rdy, input logic redir,
                               input logic [31:0] rpc, input logic rst,
                               input logic ack);
    @(negedge clock);
    reset       = rst;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (mem_auto) begin
      if (mem_req) begin
        if (wait_cnt >= ack_latency) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end else begin
      mem_ack = ack;
    end
    mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mem_auto    = 1'b1;
    ack_latency = 0;
    wait_cnt    = 0;

    // Zero-wait memory, core always ready: one instruction per cycle.
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_valid", 32'(inst_valid), 0);
    checkOutput("rst_pc", inst_pc, 0);
    checkOutput("rst_data", inst_data, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t1_first_req", 32'(mem_req), 1);
    checkOutput("t1_first_addr", mem_addr, 0);
    checkOutput("t1_not_yet_valid", 32'(inst_valid), 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("t1_valid%0d", k), 32'(inst_valid), 1);
      checkOutput($sformatf("t1_pc%0d", k), inst_pc, 32'(k));
      checkOutput($sformatf("t1_data%0d", k), inst_data, mem_word(32'(k)));
    end

    // Core stalled: exactly four entries fetched, then fetch pauses.
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_full_req", 32'(mem_req), 0);
    checkOutput("t2_full_valid", 32'(inst_valid), 1);
    checkOutput("t2_full_pc", inst_pc, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_still_idle", 32'(mem_req), 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("t2_valid%0d", k), 32'(inst_valid), 1);
      checkOutput($sformatf("t2_pc%0d", k), inst_pc, 32'(k));
      if (k == 1) begin
        checkOutput("t2_resume_req", 32'(mem_req), 1);
        checkOutput("t2_resume_addr", mem_addr, 4);
      end
    end

    // Three wait cycles per access: one instruction every four cycles.
    ack_latency = 3;
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("t3_hold_req%0d", i), 32'(mem_req), 1);
      checkOutput($sformatf("t3_hold_addr%0d", i), mem_addr, 0);
    end
    for (int i = 5; i <= 16; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput($sformatf("t3_valid%0d", i), 32'(inst_valid),
                  32'(((i - 5) % 4) == 0));
      checkOutput($sformatf("t3_addr%0d", i), mem_addr, 32'((i - 5) / 4 + 1));
      if (((i - 5) % 4) == 0) begin
        checkOutput($sformatf("t3_pc%0d", i), inst_pc, 32'((i - 5) / 4));
      end
    end

    // Redirect while the request to 0x7 waits; its late ack is discarded.
    mem_auto = 1'b0;
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 32'h5, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_addr5", mem_addr, 32'h5);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 32'h100, 0, 0);
    checkOutput("t4_pre_valid", 32'(inst_valid), 1);
    checkOutput("t4_pre_pc", inst_pc, 32'h5);
    checkOutput("t4_pre_addr", mem_addr, 32'h7);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_flushed", 32'(inst_valid), 0);
    checkOutput("t4_drop_req", 32'(mem_req), 1);
    checkOutput("t4_drop_addr", mem_addr, 32'h7);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_drop_addr2", mem_addr, 32'h7);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_no_stale", 32'(inst_valid), 0);
    checkOutput("t4_new_req", 32'(mem_req), 1);
    checkOutput("t4_new_addr", mem_addr, 32'h100);
    applyStimulus(1, 1, 32'h40, 0, 1);
    checkOutput("t4_first_valid", 32'(inst_valid), 1);
    checkOutput("t4_first_pc", inst_pc, 32'h100);
    checkOutput("t4_first_data", inst_data, mem_word(32'h100));

    // Redirect coinciding with ack and pop, then two redirects into DROP.
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5_no_push", 32'(inst_valid), 0);
    checkOutput("t5_req", 32'(mem_req), 1);
    checkOutput("t5_addr40", mem_addr, 32'h40);
    applyStimulus(0, 1, 32'h60, 0, 0);
    applyStimulus(0, 1, 32'h80, 0, 0);
    checkOutput("t5_drop_hold", mem_addr, 32'h40);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_drop_hold2", mem_addr, 32'h40);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t5_addr80", mem_addr, 32'h80);
    checkOutput("t5_empty", 32'(inst_valid), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t5_valid", 32'(inst_valid), 1);
    checkOutput("t5_pc80", inst_pc, 32'h80);
    checkOutput("t5_data80", inst_data, mem_word(32'h80));

    // Reset mid-request with two entries queued, then PC wrap-around.
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6_pre_valid", 32'(inst_valid), 1);
    checkOutput("t6_pre_pc", inst_pc, 0);
    checkOutput("t6_pre_addr", mem_addr, 32'h2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6_rst_valid", 32'(inst_valid), 0);
    checkOutput("t6_rst_req", 32'(mem_req), 0);
    checkOutput("t6_rst_pc", inst_pc, 0);
    checkOutput("t6_rst_data", inst_data, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t6_stray_ack", 32'(inst_valid), 0);
    checkOutput("t6_restart_req", 32'(mem_req), 1);
    checkOutput("t6_restart_addr", mem_addr, 0);
    applyStimulus(0, 1, 32'hFFFF_FFFF, 0, 1);
    checkOutput("t6_restart_pc", inst_pc, 0);
    checkOutput("t6_restart_data", inst_data, mem_word(0));
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t7_flush", 32'(inst_valid), 0);
    checkOutput("t7_addr_max", mem_addr, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t7_addr_wrap", mem_addr, 0);
    checkOutput("t7_pc_max", inst_pc, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t7_pc_wrap", inst_pc, 0);
    checkOutput("t7_data_wrap", inst_data, mem_word(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
